mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ARB_RR, default 0, arbitration mode: 0 = data port fixed priority, 1 = round-robin.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port ia_ren  input  1  fetch read pulse, one cycle.
REQ-005 SHALL have port ia_addr  input  32  fetch word address.
REQ-006 SHALL have port ia_rvalid  output  1  fetch data valid, one-cycle pulse.
REQ-007 SHALL have port ia_rdata  output  32  fetch read data.
REQ-008 SHALL have port da_ren  input  4  data read byte strobe, one-cycle pulse.
REQ-009 SHALL have port da_wen  input  4  data write byte strobe, one-cycle pulse.
REQ-010 SHALL have port da_addr  input  32  data word-aligned address.
REQ-011 SHALL have port da_wdata  input  32  data write data.
REQ-012 SHALL have port da_rvalid  output  1  data read complete, one-cycle pulse.
REQ-013 SHALL have port da_wdone  output  1  data write complete, one-cycle pulse.
REQ-014 SHALL have port da_rdata  output  32  data read data.
REQ-015 SHALL have port bus_ren  output  4  shared bus read strobe, one cycle per transaction.
REQ-016 SHALL have port bus_wen  output  4  shared bus write strobe, one cycle per transaction.
REQ-017 SHALL have ports bus_addr  output  32 and bus_wdata  output  32  shared bus address/data, held from strobe until completion.
REQ-018 SHALL have ports bus_valid  input  1 and bus_rdata  input  32  completion pulse and read data from the shared memory.
REQ-019 SHALL have port req_ovf  output  1  sticky error: request arrived while that port's slot was occupied.

Function
REQ-020 SHALL capture each incoming pulse (ia_ren, or da_ren/da_wen nonzero) into that port's pending slot on the same edge, with address, strobes, wdata.
REQ-021 SHALL keep one slot per port; a slot is occupied from capture until its response pulse.
REQ-022 SHALL drop a pulse arriving at an occupied slot, leave the slot unchanged, and set req_ovf.
REQ-023 SHALL treat da_wen != 0 as a write and ignore da_ren in that cycle.
REQ-024 SHALL run FSM IDLE -> ISSUE -> WAIT -> IDLE; IDLE to ISSUE when any slot is pending and not issued.
REQ-025 SHALL, in ISSUE, drive bus_ren/bus_wen nonzero for exactly that one cycle, with bus_addr/bus_wdata from the granted slot.
REQ-026 SHALL, in WAIT, hold bus_addr/bus_wdata and keep strobes 0 until bus_valid = 1.
REQ-027 SHALL, on the edge sampling bus_valid = 1 in WAIT, register bus_rdata into the granted port's rdata, pulse the matching response output for one cycle, free the slot, and return to IDLE.
REQ-028 SHALL ignore bus_valid outside WAIT.
REQ-029 SHALL, with both slots pending in IDLE and ARB_RR = 0, grant the data port.
REQ-030 SHALL, with ARB_RR = 1, grant the port not granted last; last-grant resets to fetch, so data wins first.
REQ-031 SHALL give minimum latency: pulse in cycle 0, bus strobe cycle 2, bus_valid cycle 2+L (L>=1), response cycle 3+L.
REQ-032 SHALL allow a capture into a slot on the same edge its response is issued, with the new request pending next cycle.
REQ-033 SHALL hold ia_rdata/da_rdata stable between responses.

Reset
REQ-034 SHALL on rstn low clear FSM to IDLE, both slots, last-grant to fetch, req_ovf, all strobes and response pulses to 0, rdata/bus_addr/bus_wdata to 0.
REQ-035 SHALL discard any in-flight transaction on reset and produce no response for it.

Structure
REQ-036 SHALL place FSM state encoding and port-ID constants (PORT_IF, PORT_DA) in the shared defines package.
REQ-037 SHALL implement each pending slot as sub-module arb_req_slot, instantiated twice.

Verification
REQ-038 Fetch only: ia_ren, addr 0x1C000000, memory L=1 returns 0x02C00000 -> bus_ren=4'hF cycle 2, ia_rvalid with 0x02C00000 in cycle 4.
REQ-039 Simultaneous: ia_ren addr 0x100 and da_ren addr 0x200 in cycle 0, ARB_RR=0 -> bus_addr 0x200 first, 0x100 after da_rvalid; ARB_RR=1 repeated pairs alternate.
REQ-040 Write: da_wen=4'b0100, wdata 0x00AB0000, addr 0x80 -> bus_wen=4'b0100 one cycle, bus_wdata held until bus_valid, da_wdone pulse, da_rvalid stays 0.
REQ-041 Overflow: second da_ren while first is waiting L=5 -> req_ovf=1, exactly one da_rvalid.
REQ-042 Reset mid-WAIT: rstn low during WAIT -> all outputs 0, no response pulse; new ia_ren after release serviced normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: FSM state encoding and port IDs shared by the arbiter files.
package mem_bus_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DA = 1'b1;
endpackage

// File: rtl/arb_req_slot.sv
// arb_req_slot: one pending-request slot; holds a captured request until its response frees it.
module arb_req_slot (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_cap,
   input  logic        i_free,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_ren,
   input  logic [3:0]  i_wen,
   output logic        o_busy,
   output logic        o_wr,
   output logic        o_ovf,
   output logic [31:0] o_addr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_strb
);
   logic        r_busy, r_wr;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_strb;
   logic        w_load;
   // a slot being freed this edge may accept a new request on the same edge
   assign w_load = i_cap && (!r_busy || i_free);
   assign o_ovf  = i_cap && r_busy && !i_free;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy  <= 1'b0;
         r_wr    <= 1'b0;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_strb  <= 4'h0;
      end else begin
         r_busy <= w_load || (r_busy && !i_free);
         if (w_load) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wr    <= |i_wen;
            r_strb  <= |i_wen ? i_wen : i_ren;
         end
      end
   end
   assign o_busy  = r_busy;
   assign o_wr    = r_wr;
   assign o_addr  = r_addr;
   assign o_wdata = r_wdata;
   assign o_strb  = r_strb;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between a fetch port and a data port,
// one outstanding bus transaction at a time, fixed-priority or round-robin.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ARB_RR = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ia_ren,
   input  logic [31:0] ia_addr,
   output logic        ia_rvalid,
   output logic [31:0] ia_rdata,
   input  logic [3:0]  da_ren,
   input  logic [3:0]  da_wen,
   input  logic [31:0] da_addr,
   input  logic [31:0] da_wdata,
   output logic        da_rvalid,
   output logic        da_wdone,
   output logic [31:0] da_rdata,
   output logic [3:0]  bus_ren,
   output logic [3:0]  bus_wen,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_valid,
   input  logic [31:0] bus_rdata,
   output logic        req_ovf
);
   state_t      r_state, w_next;
   logic        r_gnt, r_wr, r_ovf, r_ia_rvalid, r_da_rvalid, r_da_wdone;
   logic [3:0]  r_strb;
   logic [31:0] r_bus_addr, r_bus_wdata, r_ia_rdata, r_da_rdata;
   logic        w_if_busy, w_if_wr, w_if_ovf, w_da_busy, w_da_wr, w_da_ovf;
   logic [31:0] w_if_addr, w_if_wdata, w_da_addr, w_da_wdata;
   logic [3:0]  w_if_strb, w_da_strb;
   logic        w_start, w_sel, w_done, w_if_free, w_da_free;

   arb_req_slot u_if_slot (
      .clk(clk), .rstn(rstn), .i_cap(ia_ren), .i_free(w_if_free),
      .i_addr(ia_addr), .i_wdata(32'h0), .i_ren(4'hF), .i_wen(4'h0),
      .o_busy(w_if_busy), .o_wr(w_if_wr), .o_ovf(w_if_ovf),
      .o_addr(w_if_addr), .o_wdata(w_if_wdata), .o_strb(w_if_strb)
   );

   arb_req_slot u_da_slot (
      .clk(clk), .rstn(rstn), .i_cap((|da_ren) || (|da_wen)), .i_free(w_da_free),
      .i_addr(da_addr), .i_wdata(da_wdata), .i_ren(da_ren), .i_wen(da_wen),
      .o_busy(w_da_busy), .o_wr(w_da_wr), .o_ovf(w_da_ovf),
      .o_addr(w_da_addr), .o_wdata(w_da_wdata), .o_strb(w_da_strb)
   );

   // r_gnt keeps the last grant after completion, so it doubles as the round-robin history
   assign w_start   = (r_state == ST_IDLE) && (w_if_busy || w_da_busy);
   assign w_sel     = (w_if_busy && w_da_busy) ?
                      ((ARB_RR != 0) ? ((r_gnt == PORT_IF) ? PORT_DA : PORT_IF) : PORT_DA) :
                      (w_da_busy ? PORT_DA : PORT_IF);
   assign w_done    = (r_state == ST_WAIT) && bus_valid;
   assign w_if_free = w_done && (r_gnt == PORT_IF);
   assign w_da_free = w_done && (r_gnt == PORT_DA);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = (r_state == ST_IDLE)  ? (w_start ? ST_ISSUE : ST_IDLE) :
               (r_state == ST_ISSUE) ? ST_WAIT :
               (bus_valid ? ST_IDLE : ST_WAIT);
   end

   always_comb begin
      bus_ren = (r_state == ST_ISSUE && !r_wr) ? r_strb : 4'h0;
      bus_wen = (r_state == ST_ISSUE &&  r_wr) ? r_strb : 4'h0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_gnt       <= PORT_IF;
         r_wr        <= 1'b0;
         r_strb      <= 4'h0;
         r_bus_addr  <= 32'h0;
         r_bus_wdata <= 32'h0;
         r_ia_rdata  <= 32'h0;
         r_da_rdata  <= 32'h0;
         r_ia_rvalid <= 1'b0;
         r_da_rvalid <= 1'b0;
         r_da_wdone  <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_ia_rvalid <= w_if_free;
         r_da_rvalid <= w_da_free && !r_wr;
         r_da_wdone  <= w_da_free && r_wr;
         r_ovf       <= r_ovf || w_if_ovf || w_da_ovf;
         if (w_start) begin
            r_gnt       <= w_sel;
            r_wr        <= (w_sel == PORT_DA) ? w_da_wr    : w_if_wr;
            r_strb      <= (w_sel == PORT_DA) ? w_da_strb  : w_if_strb;
            r_bus_addr  <= (w_sel == PORT_DA) ? w_da_addr  : w_if_addr;
            r_bus_wdata <= (w_sel == PORT_DA) ? w_da_wdata : w_if_wdata;
         end
         if (w_if_free) r_ia_rdata <= bus_rdata;
         if (w_da_free && !r_wr) r_da_rdata <= bus_rdata;
      end
   end

   assign ia_rvalid = r_ia_rvalid;
   assign ia_rdata  = r_ia_rdata;
   assign da_rvalid = r_da_rvalid;
   assign da_wdone  = r_da_wdone;
   assign da_rdata  = r_da_rdata;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign req_ovf   = r_ovf;
endmodule
